// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the request/grant/response data bus from the
// EXE/MEM register, stalls the pipeline until the access ends, and formats writeback.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] alu_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic [2:0]      mem_mode_i,
    output logic [XLEN-1:0] rd_val_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            stall_o,
    output logic            misalign_o,
    output logic            fault_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    input  logic            dbus_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [XLEN-1:0]   r_dbusAddr;
    logic [3:0]        r_dbusBe;
    logic [XLEN-1:0]   r_dbusWdata;
    logic              r_dbusWe;
    logic [4:0]        r_rdAddr;
    logic              r_rdWe;
    logic              r_isLoad;
    logic [2:0]        r_mode;
    logic [1:0]        r_offset;
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_misalign;
    logic              r_fault;

    logic              w_memOp;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_loadData;

    assign w_memOp    = mem_we_i | mem_re_i;
    assign w_illegal  = mem_we_i ? (mem_mode_i[2] | (mem_mode_i[1:0] == 2'b11))
                                 : ((mem_mode_i == 3'b011) | (mem_mode_i[2:1] == 2'b11));
    assign w_misalign = ((mem_mode_i[1:0] == 2'b01) & alu_val_i[0]) |
                        ((mem_mode_i[1:0] == 2'b10) & (|alu_val_i[1:0]));
    assign w_timeout  = (r_cnt == LAST_CNT);

    assign dbus_req_o   = (r_state == S_REQ);
    assign dbus_we_o    = r_dbusWe;
    assign dbus_addr_o  = r_dbusAddr;
    assign dbus_be_o    = r_dbusBe;
    assign dbus_wdata_o = r_dbusWdata;
    assign misalign_o   = r_misalign;
    assign fault_o      = r_fault;

    // Stores put the narrow datum on every lane so the slave only has to honour the byte enables.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2_val_i;
        case (mem_mode_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_val_i[1:0];
                w_wdata = {(XLEN/8){rs2_val_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {alu_val_i[1], 1'b0};
                w_wdata = {(XLEN/16){rs2_val_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = dbus_rdata_i >> {r_offset, 3'b000};

    always_comb begin
        w_loadData = w_shifted;
        case (r_mode)
            3'b000:  w_loadData = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_loadData = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_loadData = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_loadData = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        stall_o   = 1'b0;
        rd_val_o  = alu_val_i;
        rd_addr_o = rd_addr_i;
        rd_we_o   = rd_we_i;
        case (r_state)
            S_IDLE: begin
                if (w_memOp) begin
                    stall_o = 1'b1;
                    rd_we_o = 1'b0;
                    w_next  = (w_illegal || w_misalign) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                rd_we_o = 1'b0;
                if (w_timeout) begin
                    w_next = S_DONE;
                end else if (dbus_gnt_i) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                rd_we_o = 1'b0;
                if (dbus_rvalid_i || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                rd_val_o  = r_result;
                rd_addr_o = r_rdAddr;
                rd_we_o   = r_rdWe & r_isLoad & ~r_fault & ~r_misalign;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Fault and misalign flags are set on the edge into DONE, so they pulse for exactly that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dbusAddr  <= '0;
            r_dbusBe    <= '0;
            r_dbusWdata <= '0;
            r_dbusWe    <= 1'b0;
            r_rdAddr    <= '0;
            r_rdWe      <= 1'b0;
            r_isLoad    <= 1'b0;
            r_mode      <= '0;
            r_offset    <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_misalign  <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memOp) begin
                        r_rdAddr   <= rd_addr_i;
                        r_rdWe     <= rd_we_i;
                        r_isLoad   <= ~mem_we_i;
                        r_result   <= alu_val_i;
                        r_fault    <= w_illegal;
                        r_misalign <= ~w_illegal & w_misalign;
                        if (!w_illegal && !w_misalign) begin
                            r_dbusAddr  <= {alu_val_i[XLEN-1:2], 2'b00};
                            r_dbusBe    <= w_be;
                            r_dbusWdata <= w_wdata;
                            r_dbusWe    <= mem_we_i;
                            r_mode      <= mem_mode_i;
                            r_offset    <= alu_val_i[1:0];
                            r_cnt       <= '0;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_fault <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dbus_rvalid_i) begin
                        r_result <= w_loadData;
                        r_fault  <= dbus_err_i;
                    end else if (w_timeout) begin
                        r_fault <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_fault    <= 1'b0;
                    r_misalign <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
